// File: rtl/alarm_sequencer.sv
// Alarm front end: input sync/debounce, arm/delay/alarm FSM timed in frames,
// and a frame-aligned display class for the VGA colour stage.
module alarm_sequencer #(
  parameter int DEBOUNCE_CYCLES    = 16,
  parameter int EXIT_DELAY_FRAMES  = 60,
  parameter int ENTRY_DELAY_FRAMES = 30
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       armed,
  input  logic       door,
  input  logic       window,
  input  logic       motion,
  input  logic       temperature,
  input  logic       clear,
  input  logic       vsync,
  output logic [2:0] class_out,
  output logic [2:0] state_out,
  output logic       siren,
  output logic       frame_tick
);

  typedef enum logic [2:0] {
    S_DISARMED = 3'd0,
    S_EXIT     = 3'd1,
    S_ARMED    = 3'd2,
    S_ENTRY    = 3'd3,
    S_ALARM    = 3'd4
  } state_t;

  localparam logic [7:0] DB_LAST  = 8'(DEBOUNCE_CYCLES - 1);
  localparam logic [7:0] EXIT_LD  = 8'(EXIT_DELAY_FRAMES);
  localparam logic [7:0] ENTRY_LD = 8'(ENTRY_DELAY_FRAMES);

  logic [5:0] raw;
  logic [5:0] sync1;
  logic [5:0] sync2;
  logic [5:0] db;
  logic [7:0] cnt [6];

  assign raw = {clear, temperature, motion, window, door, armed};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= raw;
      sync2 <= sync1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      db <= '0;
      for (int i = 0; i < 6; i++) cnt[i] <= '0;
    end else begin
      for (int i = 0; i < 6; i++) begin
        if (sync2[i] == db[i]) begin
          cnt[i] <= '0;
        end else if (cnt[i] == DB_LAST) begin
          db[i]  <= sync2[i];
          cnt[i] <= '0;
        end else begin
          cnt[i] <= cnt[i] + 8'd1;
        end
      end
    end
  end

  logic arm_d, door_d, win_d, mot_d, temp_d, clr_d;
  assign arm_d  = db[0];
  assign door_d = db[1];
  assign win_d  = db[2];
  assign mot_d  = db[3];
  assign temp_d = db[4];
  assign clr_d  = db[5];

  // run masks the first cycle after reset so a vsync already low is no edge
  logic vsync_q;
  logic run;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vsync_q <= 1'b1;
      run     <= 1'b0;
    end else begin
      vsync_q <= vsync;
      run     <= 1'b1;
    end
  end

  assign frame_tick = run & vsync_q & ~vsync;

  state_t     state;
  state_t     nstate;
  logic       cause;
  logic       ncause;
  logic [7:0] timer;
  logic [2:0] nclass;
  logic       expire;

  assign expire = frame_tick && (timer == 8'd1);

  always_comb begin
    nstate = state;
    ncause = cause;
    if (clr_d) begin
      nstate = S_DISARMED;
    end else if (state == S_ALARM) begin
      nstate = S_ALARM;
    end else if (!arm_d && state != S_DISARMED) begin
      nstate = S_DISARMED;
    end else begin
      case (state)
        S_DISARMED: if (arm_d) nstate = S_EXIT;
        S_EXIT:     if (expire) nstate = S_ARMED;
        S_ARMED: begin
          if (door_d && mot_d) begin
            nstate = S_ENTRY;
          end else if (win_d) begin
            nstate = S_ALARM;
            ncause = 1'b1;
          end
        end
        S_ENTRY: begin
          if (expire) begin
            nstate = S_ALARM;
            ncause = 1'b0;
          end else if (win_d) begin
            nstate = S_ALARM;
            ncause = 1'b1;
          end
        end
        default: nstate = S_DISARMED;
      endcase
    end
  end

  always_comb begin
    nclass = 3'd0;
    priority case (1'b1)
      clr_d:                                nclass = 3'd0;
      temp_d:                               nclass = 3'd3;
      (state == S_ALARM):                   nclass = cause ? 3'd2 : 3'd1;
      (state == S_EXIT || state == S_ENTRY): nclass = 3'd4;
      default:                              nclass = 3'd0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_DISARMED;
      cause     <= 1'b0;
      timer     <= '0;
      class_out <= '0;
    end else begin
      state <= nstate;
      if (nstate == S_ALARM && state != S_ALARM) cause <= ncause;
      if (nstate != state && nstate == S_EXIT) begin
        timer <= EXIT_LD;
      end else if (nstate != state && nstate == S_ENTRY) begin
        timer <= ENTRY_LD;
      end else if (frame_tick && timer != 8'd0) begin
        timer <= timer - 8'd1;
      end
      if (frame_tick) class_out <= nclass;
    end
  end

  assign state_out = state;
  assign siren     = (state == S_ALARM);

endmodule

// File: tb/tb_alarm_sequencer.sv
// Directed bench for alarm_sequencer: vector table over frame ticks
// plus hand sequences for debounce, disarm race and async reset.
module tb_alarm_sequencer;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       armed = 1'b0, door = 1'b0, window = 1'b0;
  logic       motion = 1'b0, temperature = 1'b0, clear = 1'b0;
  logic       vsync = 1'b0;
  logic [2:0] class_out;
  logic [2:0] state_out;
  logic       siren;
  logic       frame_tick;

  alarm_sequencer #(
    .DEBOUNCE_CYCLES(4),
    .EXIT_DELAY_FRAMES(2),
    .ENTRY_DELAY_FRAMES(2)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .armed(armed),
    .door(door),
    .window(window),
    .motion(motion),
    .temperature(temperature),
    .clear(clear),
    .vsync(vsync),
    .class_out(class_out),
    .state_out(state_out),
    .siren(siren),
    .frame_tick(frame_tick)
  );

  always #5 clk = ~clk;

  // vsync low 2 of every 50 cycles once enabled
  int   vcnt = 2;
  logic gen_on = 1'b0;
  initial forever begin
    @(posedge clk);
    #2;
    if (gen_on) begin
      vcnt  = (vcnt == 49) ? 0 : vcnt + 1;
      vsync = (vcnt >= 2);
    end
  end

  int ticks = 0;
  always @(posedge clk) if (rst_n && frame_tick) ticks++;

  int n_vec = 0;
  int n_bad = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic wait_tick();
    int t0;
    int k;
    t0 = ticks;
    k = 0;
    while (ticks == t0 && k < 200) begin
      @(negedge clk);
      k++;
    end
    if (ticks == t0) begin
      n_vec++;
      n_bad++;
      $display("FAIL wait_tick: got no tick expected one within 200 cycles");
    end
    repeat (2) @(negedge clk);
  endtask

  typedef struct {
    logic [5:0] in;
    logic [2:0] st;
    logic       sir;
    logic [2:0] cls;
  } vec_t;

  vec_t tbl [14];

  task automatic drive(input logic [5:0] v);
    {clear, temperature, motion, window, door, armed} = v;
  endtask

  initial begin
    int k;
    // {clear,temperature,motion,window,door,armed}
    tbl[0]  = '{6'b001011, 3'd3, 1'b0, 3'd4};
    tbl[1]  = '{6'b000001, 3'd4, 1'b1, 3'd4};
    tbl[2]  = '{6'b000001, 3'd4, 1'b1, 3'd1};
    tbl[3]  = '{6'b000000, 3'd4, 1'b1, 3'd1};
    tbl[4]  = '{6'b100000, 3'd0, 1'b0, 3'd0};
    tbl[5]  = '{6'b100001, 3'd0, 1'b0, 3'd0};
    tbl[6]  = '{6'b000001, 3'd1, 1'b0, 3'd4};
    tbl[7]  = '{6'b000001, 3'd2, 1'b0, 3'd4};
    tbl[8]  = '{6'b000001, 3'd2, 1'b0, 3'd0};
    tbl[9]  = '{6'b000101, 3'd4, 1'b1, 3'd2};
    tbl[10] = '{6'b010101, 3'd4, 1'b1, 3'd3};
    tbl[11] = '{6'b000001, 3'd4, 1'b1, 3'd2};
    tbl[12] = '{6'b100000, 3'd0, 1'b0, 3'd0};
    tbl[13] = '{6'b000000, 3'd0, 1'b0, 3'd0};

    #3;
    chk("reset state", state_out, 0);
    chk("reset siren", siren, 0);
    chk("reset class", class_out, 0);
    chk("reset frame_tick", frame_tick, 0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    chk("no tick from low vsync at release", ticks, 0);
    gen_on = 1'b1;
    wait_tick();

    armed = 1'b1;
    repeat (3) @(negedge clk);
    armed = 1'b0;
    repeat (20) @(negedge clk);
    chk("glitch filtered", state_out, 0);

    wait_tick();
    armed = 1'b1;
    repeat (6) @(negedge clk);
    chk("arm latency-1", state_out, 0);
    @(negedge clk);
    chk("arm latency", state_out, 1);
    wait_tick();
    chk("exit class", class_out, 4);
    chk("exit state tick1", state_out, 1);

    door = 1'b1;
    motion = 1'b1;
    repeat (20) @(negedge clk);
    chk("exit ignores door+motion", state_out, 1);
    door = 1'b0;
    motion = 1'b0;
    wait_tick();
    chk("exit expiry state", state_out, 2);
    wait_tick();
    chk("armed class", class_out, 0);
    chk("armed state", state_out, 2);

    for (int i = 0; i < 14; i++) begin
      drive(tbl[i].in);
      wait_tick();
      chk($sformatf("vec%0d state", i), state_out, tbl[i].st);
      chk($sformatf("vec%0d siren", i), siren, tbl[i].sir);
      chk($sformatf("vec%0d class", i), class_out, tbl[i].cls);
    end

    armed = 1'b1;
    wait_tick();
    wait_tick();
    chk("race setup armed", state_out, 2);
    door = 1'b1;
    motion = 1'b1;
    wait_tick();
    chk("race setup entry", state_out, 3);
    k = 0;
    while (vcnt != 44 && k < 100) begin
      @(negedge clk);
      k++;
    end
    chk("race align vcnt", vcnt, 44);
    armed = 1'b0;
    door = 1'b0;
    motion = 1'b0;
    repeat (6) @(negedge clk);
    chk("race tick cycle frame_tick", frame_tick, 1);
    chk("race tick cycle state", state_out, 3);
    @(negedge clk);
    chk("race state", state_out, 0);
    chk("race siren", siren, 0);

    armed = 1'b1;
    wait_tick();
    wait_tick();
    window = 1'b1;
    wait_tick();
    chk("pre-reset siren", siren, 1);
    chk("pre-reset class", class_out, 2);
    #3;
    rst_n = 1'b0;
    #1;
    chk("async reset siren", siren, 0);
    chk("async reset state", state_out, 0);
    chk("async reset class", class_out, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
